// File: rtl/uart_tx_top_if.sv
// Register bus between the SoC address decoder / read mux and the UART transmitter.
interface uart_tx_top_if;
    logic [1:0]  a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output a, output we, output wd, input rd);
    modport slave  (input a, input we, input wd, output rd);
endinterface

// File: rtl/uart_tx_top.sv
// Memory-mapped UART transmitter: byte FIFO, baud counter and 8N1 serialiser.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_top #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_top_if.slave bus,
    output logic         txd
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, count;
    logic          empty, full, push_req, push, pop, ovf, en;
    logic [15:0]   div, div_m1;
    logic [7:0]    head;

    state_t        state, state_d;
    logic [7:0]    shift, shift_d;
    logic [2:0]    idx, idx_d;
    logic [15:0]   baud, baud_d;
    logic          bit_end, launch, txd_d;
`ifdef UART_TX_PARITY_EN
    logic          par, par_d;
`endif
    logic          unused_wd;

    assign unused_wd = ^bus.wd[31:16];

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req = bus.we && (bus.a == 2'd0);
    assign push     = push_req && (!full || pop);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign div_m1   = (div == 16'd0) ? 16'd0 : div - 16'd1;
    assign bit_end  = (baud == 16'd0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.wd[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            div    <= DIV_RESET;
            en     <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push_req && full && !pop)       ovf <= 1'b1;
            else if (bus.we && bus.a == 2'd1)   ovf <= 1'b0;
            if (bus.we && bus.a == 2'd2) div <= bus.wd[15:0];
            if (bus.we && bus.a == 2'd3) en  <= bus.wd[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            shift <= '0;
            idx   <= '0;
            baud  <= '0;
            txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            shift <= shift_d;
            idx   <= idx_d;
            baud  <= baud_d;
            txd   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par   <= par_d;
`endif
        end
    end

    // Next state; a frame may launch from IDLE or straight out of STOP.
    always_comb begin
        state_d = state;
        shift_d = shift;
        idx_d   = idx;
        baud_d  = baud;
        launch  = 1'b0;
        pop     = 1'b0;
        txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par;
`endif
        if (state != S_IDLE && !bit_end) baud_d = baud - 16'd1;
        case (state)
            S_IDLE:  launch = en && !empty;
            S_START: if (bit_end) begin
                state_d = S_DATA;
                idx_d   = 3'd0;
                baud_d  = div_m1;
            end
            S_DATA:  if (bit_end) begin
                shift_d = {1'b0, shift[7:1]};
                idx_d   = idx + 3'd1;
                baud_d  = div_m1;
`ifdef UART_TX_PARITY_EN
                if (idx == 3'd7) state_d = S_PAR;
`else
                if (idx == 3'd7) state_d = S_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            S_PAR:   if (bit_end) begin
                state_d = S_STOP;
                baud_d  = div_m1;
            end
`endif
            S_STOP:  if (bit_end) begin
                state_d = S_IDLE;
                launch  = en && !empty;
            end
            default: state_d = S_IDLE;
        endcase
        if (launch) begin
            pop     = 1'b1;
            shift_d = head;
            baud_d  = div_m1;
            state_d = S_START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
        end
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PAR:   txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    // Read mux is combinational so loads complete in the same cycle.
    always_comb begin
        bus.rd = 32'd0;
        case (bus.a)
            2'd1:    bus.rd = {24'd0, 4'(count), ovf, (state != S_IDLE), full, empty};
            2'd2:    bus.rd = {16'd0, div};
            2'd3:    bus.rd = {31'd0, en};
            default: bus.rd = 32'd0;
        endcase
    end
endmodule
